regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the next-generation RV32 core, replacing the fixed 2R/1W file in the pipelined datapath. It provides NRP read ports and two write ports (ALU writeback and late load return) with fixed write priority and optional write-to-read bypass. It also carries a per-register pending scoreboard so decode can stall on in-flight producers. Reads are combinational, or registered with a parameter-selected 1-cycle latency.

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers; power of two, ≥2; AW = $clog2(NREGS)
- NRP, 2, number of read ports, 1..4
- ZERO_REG, 1, 1: register 0 is hardwired to zero, never written, never pending
- BYPASS, 1, 1: a same-cycle write is forwarded to matching read ports
- SYNC_READ, 0, 0: combinational reads; 1: registered read outputs
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all registers and all pending bits
- rs_addr  in  NRP*AW  read addresses; port p uses [p*AW +: AW]
- rd_data  out  NRP*XLEN  read data; port p uses [p*XLEN +: XLEN]
- rd_ready  out  NRP  1 = no pending producer for the addressed register
- we0, wa0, wd0  in  1/AW/XLEN  write port 0 (ALU writeback)
- we1, wa1, wd1  in  1/AW/XLEN  write port 1 (load return); has priority over port 0
- alloc_en, alloc_rd  in  1/AW  mark a register pending (issue of a producer)

## Operation
- Write: at the rising edge, `we0` writes wd0 to wa0 and `we1` writes wd1 to wa1. If both target the same address, wd1 is stored. With ZERO_REG=1, writes to address 0 are dropped.
- Pending bit semantics:
  - A write on either port clears pending[wa].
  - alloc_en sets pending[alloc_rd].
  - Alloc and write to the same register in the same cycle: pending ends up 1, because the newer producer wins.
  - With ZERO_REG=1, address 0 is never set.
- Read value, port p, with addr = rs_addr[p]:
  - If ZERO_REG and addr==0: returns 0.
  - Else if BYPASS and we1 && wa1==addr: returns wd1.
  - Else if BYPASS and we0 && wa0==addr: returns wd0.
  - Else: returns regs[addr].
- rd_ready[p] = !pending[addr] || (BYPASS && a write to addr is present this cycle). A same-cycle alloc to addr does not affect rd_ready until the next edge.
- With BYPASS=0, a read of a register being written returns the old value, and rd_ready reflects the old pending bit.

## Timing
- SYNC_READ=0: rd_data and rd_ready are combinational from rs_addr, write ports and state; 0-cycle latency.
- SYNC_READ=1: the value computed above is registered at the rising edge, so the output in cycle n+1 corresponds to the address in cycle n. The bypass term uses the cycle-n write, so a write and read of the same address in one cycle returns the new data one cycle later regardless of BYPASS.
- Reset, asserted at any time, including mid-write:
  - All regs become 0 and all pending bits become 0.
  - Registered outputs (SYNC_READ=1): rd_data=0, rd_ready all 1.
  - Combinational outputs follow the cleared state.
  - Writes and allocs in a cycle where reset is high are ignored.
- No handshakes: the block never back-pressures. Stalling on rd_ready=0 is the consumer's responsibility.

## Structure
- Shared package `rv_pkg`: XLEN, NREGS, AW, and constant REG_ZERO = 0. The core and this block share these definitions.
- One natural sub-module, `rf_read_port`: per-port bypass/zero/ready mux plus the optional output register. It is instantiated NRP times in a generate loop. Storage, write logic and the scoreboard stay in the top module.

## Test plan
- Reset then read: assert reset mid-run after writing x5=0xDEADBEEF; read x5 on all ports -> 0 with rd_ready=1; with SYNC_READ=1, rd_data=0 immediately on reset assertion.
- Dual-write conflict: we0 wa0=7 wd0=0x11, we1 wa1=7 wd1=0x22 in the same cycle; next cycle read x7 -> 0x22. A second case writes different addresses (3 and 4) and checks both stored.
- Zero register: write x0=0xFFFFFFFF, alloc x0; read x0 -> 0 with rd_ready=1. Repeat with ZERO_REG=0 -> 0xFFFFFFFF, rd_ready=0.
- Bypass: BYPASS=1 SYNC_READ=0, x9=0x1, same-cycle we0 wa0=9 wd0=0x55 -> rd_data=0x55. BYPASS=0 -> 0x1 that cycle, 0x55 next.
- Scoreboard: alloc x12 -> rd_ready for x12 = 0 next cycle. we1 wa1=12 wd1=0x77 -> rd_ready=1 the same cycle with data 0x77 (BYPASS=1). Simultaneous alloc x12 and write x12 -> pending=1 afterwards.
- Sync read latency: SYNC_READ=1, NRP=4, sequence addresses 1,2,3,4 on port 0 with regs holding 0x10..0x40 -> outputs 0x10,0x20,0x30,0x40, each one cycle delayed. Other ports are checked independently with distinct addresses.

Source files
------------

// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 core definitions (data width, register count, address width, zero register index)
package rv_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = $clog2(NREGS);
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one register-file read port with zero/bypass/ready selection and optional output register
//   clk, reset          clock, async active-high reset (clears the output register)
//   addr_i              register address for this port
//   reg_i, pend_i       stored value and pending bit of the addressed register
//   we0_i/wa0_i/wd0_i   write port 0 (ALU writeback)
//   we1_i/wa1_i/wd1_i   write port 1 (load return, higher priority)
//   data_o, ready_o     read data and "no pending producer" flag
module rf_read_port #(
  parameter int XLEN = 32,
  parameter int AW = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  parameter bit SYNC_READ = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] reg_i,
  input  logic            pend_i,
  input  logic            we0_i,
  input  logic [AW-1:0]   wa0_i,
  input  logic [XLEN-1:0] wd0_i,
  input  logic            we1_i,
  input  logic [AW-1:0]   wa1_i,
  input  logic [XLEN-1:0] wd1_i,
  output logic [XLEN-1:0] data_o,
  output logic            ready_o
);
  import rv_pkg::REG_ZERO;
  // A registered read captures the value as it will stand after the edge,
  // so forwarding is always applied when the output is registered.
  localparam bit FWD = BYPASS || SYNC_READ;
  logic            is_zero, hit0, hit1, ready_d, ready_q;
  logic [XLEN-1:0] data_d, data_q;
  assign is_zero = ZERO_REG && addr_i == AW'(REG_ZERO);
  assign hit0 = FWD && we0_i && wa0_i == addr_i;
  assign hit1 = FWD && we1_i && wa1_i == addr_i;
  assign data_d = is_zero ? '0 : hit1 ? wd1_i : hit0 ? wd0_i : reg_i;
  assign ready_d = !pend_i || hit0 || hit1;
  // In combinational mode these flops have no load and are trimmed away.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  assign data_o  = SYNC_READ ? data_q : data_d;
  assign ready_o = SYNC_READ ? ready_q : ready_d;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two prioritised write ports, bypass and pending scoreboard
//   clk, reset           clock, async active-high reset (clears registers and pending bits)
//   rs_addr              NRP packed read addresses, port p at [p*AW +: AW]
//   rd_data, rd_ready    NRP packed read data and per-port ready flags
//   we0/wa0/wd0          write port 0 (ALU writeback)
//   we1/wa1/wd1          write port 1 (load return, wins on address conflict)
//   alloc_en, alloc_rd   mark a register pending when a producer issues
module regfile_mp #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREGS = rv_pkg::NREGS,
  parameter int NRP = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1,
  parameter bit SYNC_READ = 1'b0,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rd_data,
  output logic [NRP-1:0]      rd_ready,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [XLEN-1:0]     wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [XLEN-1:0]     wd1,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_rd
);
  import rv_pkg::REG_ZERO;
  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;
  function automatic logic wr_ok(input logic [AW-1:0] a);
    return !(ZERO_REG && a == AW'(REG_ZERO));
  endfunction
  // Port 1 is applied after port 0 so it wins on a shared address; alloc is
  // applied last so a newly issued producer outranks a completing one.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (we0) pend_d[wa0] = 1'b0;
    if (we1) pend_d[wa1] = 1'b0;
    if (we0 && wr_ok(wa0)) regs_d[wa0] = wd0;
    if (we1 && wr_ok(wa1)) regs_d[wa1] = wd1;
    if (alloc_en && wr_ok(alloc_rd)) pend_d[alloc_rd] = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  for (genvar p = 0; p < NRP; p++) begin : g_rp
    logic [AW-1:0] a;
    assign a = rs_addr[p*AW +: AW];
    rf_read_port #(
      .XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .SYNC_READ(SYNC_READ)
    ) u_rp (
      .clk(clk), .reset(reset), .addr_i(a), .reg_i(regs_q[a]), .pend_i(pend_q[a]),
      .we0_i(we0), .wa0_i(wa0), .wd0_i(wd0), .we1_i(we1), .wa1_i(wa1), .wd1_i(wd1),
      .data_o(rd_data[p*XLEN +: XLEN]), .ready_o(rd_ready[p])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed self-checking bench for regfile_mp in three configurations
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [4*AW-1:0] rs_addr = '0;
  logic we0 = 0, we1 = 0, alloc_en = 0;
  logic [AW-1:0] wa0 = '0, wa1 = '0, alloc_rd = '0;
  logic [XLEN-1:0] wd0 = '0, wd1 = '0;
  logic [2*XLEN-1:0] d_a, d_b;
  logic [1:0] r_a, r_b;
  logic [4*XLEN-1:0] d_s;
  logic [3:0] r_s;
  int checks = 0, errors = 0;
  regfile_mp #(.NRP(2)) u_a (
    .clk(clk), .reset(reset), .rs_addr(rs_addr[2*AW-1:0]), .rd_data(d_a), .rd_ready(r_a),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd));
  regfile_mp #(.NRP(2), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .clk(clk), .reset(reset), .rs_addr(rs_addr[2*AW-1:0]), .rd_data(d_b), .rd_ready(r_b),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd));
  regfile_mp #(.NRP(4), .SYNC_READ(1'b1)) u_s (
    .clk(clk), .reset(reset), .rs_addr(rs_addr), .rd_data(d_s), .rd_ready(r_s),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd));
  // reference model: index 0 = u_a, 1 = u_b, 2 = u_s
  bit cz [3] = '{1'b1, 1'b0, 1'b1};
  bit cb [3] = '{1'b1, 1'b0, 1'b1};
  logic [XLEN-1:0] m_regs [3][NREGS];
  bit m_pend [3][NREGS];
  logic [XLEN-1:0] s_exp_d [4];
  bit s_exp_r [4];
  function automatic logic [XLEN-1:0] m_data(int k, int a);
    if (cz[k] && a == 0) return '0;
    if (cb[k] && we1 && int'(wa1) == a) return wd1;
    if (cb[k] && we0 && int'(wa0) == a) return wd0;
    return m_regs[k][a];
  endfunction
  function automatic bit m_ready(int k, int a);
    return !m_pend[k][a] || (cb[k] && ((we1 && int'(wa1) == a) || (we0 && int'(wa0) == a)));
  endfunction
  task automatic m_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < NREGS; i++) begin
        m_regs[k][i] = '0;
        m_pend[k][i] = 0;
      end
    for (int p = 0; p < 4; p++) begin
      s_exp_d[p] = '0;
      s_exp_r[p] = 1;
    end
  endtask
  task automatic m_clock();
    for (int k = 0; k < 3; k++) begin
      if (we0) begin
        if (!(cz[k] && wa0 == 0)) m_regs[k][wa0] = wd0;
        m_pend[k][wa0] = 0;
      end
      if (we1) begin
        if (!(cz[k] && wa1 == 0)) m_regs[k][wa1] = wd1;
        m_pend[k][wa1] = 0;
      end
      if (alloc_en && !(cz[k] && alloc_rd == 0)) m_pend[k][alloc_rd] = 1;
    end
  endtask
  task automatic tick();
    int a;
    @(posedge clk);
    for (int p = 0; p < 4; p++) begin
      a = int'(rs_addr[p*AW +: AW]);
      s_exp_d[p] = reset ? '0 : m_data(2, a);
      s_exp_r[p] = reset ? 1'b1 : m_ready(2, a);
    end
    if (!reset) m_clock();
    #1;
  endtask
  task automatic idle();
    we0 = 0; we1 = 0; alloc_en = 0;
  endtask
  task automatic set_rs(input int a0, input int a1, input int a2, input int a3);
    rs_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endtask
  task automatic test_reset();
    reset = 1; idle(); set_rs(0, 0, 0, 0); m_reset();
    tick(); tick();
    reset = 0;
    #2;
    checks++; if (r_a !== 2'b11) begin errors++; $display("FAIL reset_ready_a: got %b expected 11", r_a); end
    checks++; if (d_b !== '0) begin errors++; $display("FAIL reset_data_b: got %h expected 0", d_b); end
    checks++; if (d_s !== '0 || r_s !== 4'hf) begin errors++; $display("FAIL reset_sync: got %h/%h expected 0/f", d_s, r_s); end
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    tick();
    idle(); set_rs(5, 5, 5, 5);
    #2;
    checks++; if (d_a[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_x5: got %h expected deadbeef", d_a[31:0]); end
    reset = 1; m_reset();
    #1;
    checks++; if (d_s !== '0 || r_s !== 4'hf) begin errors++; $display("FAIL async_reset_sync: got %h/%h expected 0/f", d_s, r_s); end
    checks++; if (d_a !== '0 || r_a !== 2'b11) begin errors++; $display("FAIL async_reset_comb: got %h/%b expected 0/11", d_a, r_a); end
    we1 = 1; wa1 = 5; wd1 = 32'h1234; alloc_en = 1; alloc_rd = 5;
    tick();
    reset = 0; idle();
    #2;
    checks++; if (d_b !== '0 || r_b !== 2'b11) begin errors++; $display("FAIL write_in_reset: got %h/%b expected 0/11", d_b, r_b); end
  endtask
  task automatic test_dual_write();
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22;
    tick();
    idle(); set_rs(7, 7, 7, 7);
    #2;
    checks++; if (d_a[31:0] !== 32'h22) begin errors++; $display("FAIL conflict_a: got %h expected 22", d_a[31:0]); end
    checks++; if (d_b[31:0] !== 32'h22) begin errors++; $display("FAIL conflict_b: got %h expected 22", d_b[31:0]); end
    we0 = 1; wa0 = 3; wd0 = 32'h33; we1 = 1; wa1 = 4; wd1 = 32'h44;
    tick();
    idle(); set_rs(3, 4, 3, 4);
    #2;
    checks++; if (d_a !== {32'h44, 32'h33}) begin errors++; $display("FAIL split_write: got %h expected 0000004400000033", d_a); end
  endtask
  task automatic test_zero();
    we0 = 1; wa0 = 0; wd0 = 32'hFFFFFFFF; alloc_en = 1; alloc_rd = 0;
    tick();
    idle(); set_rs(0, 0, 0, 0);
    #2;
    checks++; if (d_a[31:0] !== '0 || r_a[0] !== 1'b1) begin errors++; $display("FAIL zero_hard: got %h/%b expected 0/1", d_a[31:0], r_a[0]); end
    checks++; if (d_b[31:0] !== 32'hFFFFFFFF || r_b[0] !== 1'b0) begin errors++; $display("FAIL zero_soft: got %h/%b expected ffffffff/0", d_b[31:0], r_b[0]); end
  endtask
  task automatic test_bypass();
    we0 = 1; wa0 = 9; wd0 = 32'h1;
    tick();
    wd0 = 32'h55; set_rs(9, 9, 9, 9);
    #2;
    checks++; if (d_a[31:0] !== 32'h55) begin errors++; $display("FAIL bypass_on: got %h expected 55", d_a[31:0]); end
    checks++; if (d_b[31:0] !== 32'h1) begin errors++; $display("FAIL bypass_off: got %h expected 1", d_b[31:0]); end
    tick();
    checks++; if (d_s[31:0] !== 32'h55) begin errors++; $display("FAIL bypass_sync: got %h expected 55", d_s[31:0]); end
    idle();
    #2;
    checks++; if (d_b[31:0] !== 32'h55) begin errors++; $display("FAIL bypass_off_next: got %h expected 55", d_b[31:0]); end
  endtask
  task automatic test_scoreboard();
    alloc_en = 1; alloc_rd = 12;
    tick();
    idle(); set_rs(12, 12, 12, 12);
    #2;
    checks++; if (r_a[0] !== 1'b0 || r_b[0] !== 1'b0) begin errors++; $display("FAIL alloc_pending: got %b/%b expected 0/0", r_a[0], r_b[0]); end
    we1 = 1; wa1 = 12; wd1 = 32'h77;
    #2;
    checks++; if (r_a[0] !== 1'b1 || d_a[31:0] !== 32'h77) begin errors++; $display("FAIL ready_bypass: got %b/%h expected 1/77", r_a[0], d_a[31:0]); end
    checks++; if (r_b[0] !== 1'b0) begin errors++; $display("FAIL ready_nobypass: got %b expected 0", r_b[0]); end
    tick();
    idle();
    #2;
    checks++; if (r_a[0] !== 1'b1 || r_b[0] !== 1'b1) begin errors++; $display("FAIL write_clears: got %b/%b expected 1/1", r_a[0], r_b[0]); end
    alloc_en = 1; alloc_rd = 12; we0 = 1; wa0 = 12; wd0 = 32'h88;
    #2;
    checks++; if (r_a[0] !== 1'b1) begin errors++; $display("FAIL alloc_same_cycle: got %b expected 1", r_a[0]); end
    tick();
    idle();
    #2;
    checks++; if (r_a[0] !== 1'b0 || r_b[0] !== 1'b0 || d_a[31:0] !== 32'h88) begin errors++; $display("FAIL alloc_wins: got %b/%b/%h expected 0/0/88", r_a[0], r_b[0], d_a[31:0]); end
  endtask
  task automatic test_sync_latency();
    for (int i = 1; i <= 4; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = XLEN'(i * 16);
      tick();
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      set_rs(i, i + 4, i + 8, i + 16);
      #2;
      if (i > 1) begin
        checks++; if (d_s[31:0] !== XLEN'((i - 1) * 16)) begin errors++; $display("FAIL sync_hold_%0d: got %h expected %h", i, d_s[31:0], (i - 1) * 16); end
      end
      tick();
      checks++; if (d_s[31:0] !== XLEN'(i * 16)) begin errors++; $display("FAIL sync_lat_%0d: got %h expected %h", i, d_s[31:0], i * 16); end
      for (int p = 1; p < 4; p++) begin
        checks++; if (d_s[p*XLEN +: XLEN] !== s_exp_d[p] || r_s[p] !== s_exp_r[p]) begin errors++; $display("FAIL sync_port%0d_%0d: got %h/%b expected %h/%b", p, i, d_s[p*XLEN +: XLEN], r_s[p], s_exp_d[p], s_exp_r[p]); end
      end
    end
  endtask
  function automatic int rnd_addr();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
  endfunction
  task automatic test_random();
    int a;
    for (int n = 0; n < 400; n++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = AW'(rnd_addr()); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = AW'(rnd_addr()); wd1 = $urandom;
      alloc_en = 1'($urandom_range(0, 1)); alloc_rd = AW'(rnd_addr());
      set_rs(rnd_addr(), rnd_addr(), rnd_addr(), rnd_addr());
      if ($urandom_range(0, 39) == 0) begin
        reset = 1; m_reset();
      end else reset = 0;
      #2;
      for (int p = 0; p < 2; p++) begin
        a = int'(rs_addr[p*AW +: AW]);
        checks++; if (d_a[p*XLEN +: XLEN] !== m_data(0, a) || r_a[p] !== m_ready(0, a)) begin errors++; $display("FAIL rand_a n=%0d p=%0d x%0d: got %h/%b expected %h/%b", n, p, a, d_a[p*XLEN +: XLEN], r_a[p], m_data(0, a), m_ready(0, a)); end
        checks++; if (d_b[p*XLEN +: XLEN] !== m_data(1, a) || r_b[p] !== m_ready(1, a)) begin errors++; $display("FAIL rand_b n=%0d p=%0d x%0d: got %h/%b expected %h/%b", n, p, a, d_b[p*XLEN +: XLEN], r_b[p], m_data(1, a), m_ready(1, a)); end
      end
      tick();
      for (int p = 0; p < 4; p++) begin
        checks++; if (d_s[p*XLEN +: XLEN] !== s_exp_d[p] || r_s[p] !== s_exp_r[p]) begin errors++; $display("FAIL rand_s n=%0d p=%0d: got %h/%b expected %h/%b", n, p, d_s[p*XLEN +: XLEN], r_s[p], s_exp_d[p], s_exp_r[p]); end
      end
    end
    reset = 0; idle();
  endtask
  initial begin
    test_reset();
    test_dual_write();
    test_zero();
    test_bypass();
    test_scoreboard();
    test_sync_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
